// File: rtl/percept_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial perceptron controller.
package percept_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    FLUSH = 3'd3,
    FMAC  = 3'd4,
    READ  = 3'd5,
    DONE  = 3'd6
  } state_e;

  localparam int unsigned DEF_SIZE = 32;

  function automatic int unsigned load_len(input int unsigned size);
    return 2 * size;
  endfunction

  function automatic int unsigned read_len(input int unsigned size);
    return 4 * size + 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned size);
    return 4 * size;
  endfunction

  localparam int unsigned LOAD_LEN = load_len(DEF_SIZE);
  localparam int unsigned READ_LEN = read_len(DEF_SIZE);
  localparam int unsigned ACC_W    = acc_w(DEF_SIZE);
  localparam int unsigned CNT_W    = $clog2(READ_LEN + 1);

endpackage

// File: rtl/percept_serdes.sv
// Operand parallel-to-serial register feeding the datapath, and the serial-to-parallel
// result register filled from the datapath readout (MSB first).
import percept_pkg::*;

module percept_serdes #(
  parameter int unsigned SIZE = 32
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                load_i,
  input  logic [SIZE-1:0]     a_i,
  input  logic [SIZE-1:0]     b_i,
  input  logic                shift_i,
  input  logic                cap_i,
  input  logic                sdo_i,
  output logic                ser_o,
  output logic [4*SIZE-1:0]   par_o
);

  logic [2*SIZE-1:0] sreg_q, sreg_d;
  logic [4*SIZE-1:0] res_q, res_d;

  // Next-state for the operand shifter and the result capture register.
  always_comb begin
    sreg_d = sreg_q;
    res_d  = res_q;
    if (load_i) begin
      sreg_d = {a_i, b_i};
    end else if (shift_i) begin
      // Zero fill leaves the shifter empty after a full load, so the serial line idles low.
      sreg_d = {sreg_q[2*SIZE-2:0], 1'b0};
    end else begin
      sreg_d = sreg_q;
    end
    if (cap_i) begin
      res_d = {res_q[4*SIZE-2:0], sdo_i};
    end else begin
      res_d = res_q;
    end
  end

  // Register update.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sreg_q <= '0;
      res_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      res_q  <= res_d;
    end
  end

  assign ser_o = sreg_q[2*SIZE-1];
  assign par_o = res_q;

endmodule

// File: rtl/percept_ctrl.sv
// Sequencing FSM for one bit-serial perceptron datapath: loads operand pairs,
// strobes the MAC, flushes the product pipeline and reads back the accumulator.
import percept_pkg::*;

module percept_ctrl #(
  parameter int unsigned SIZE = 32
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [SIZE-1:0]     in_a_i,
  input  logic [SIZE-1:0]     in_b_i,
  input  logic                in_last_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [4*SIZE-1:0]   result_o,
  output logic                busy_o,
  output logic                pc_shift_in_o,
  output logic                pc_shift_out_o,
  output logic                pc_mul_and_acc_o,
  output logic                pc_data_in_o,
  input  logic                pc_data_out_i
);

  localparam int unsigned LD_N = load_len(SIZE);
  localparam int unsigned RD_N = read_len(SIZE);
  localparam int unsigned AW   = acc_w(SIZE);
  localparam int unsigned CW   = $clog2(RD_N + 1);
  localparam logic [CW-1:0] LD_LAST = CW'(LD_N - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_N - 1);
  localparam logic [CW-1:0] AW_CNT  = CW'(AW);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          load_s, shift_s, cap_s;
  logic          in_ready_q, res_valid_q, busy_q;
  logic          shift_in_q, shift_out_q, mac_q;

  // Next-state, cycle counter and serdes enables.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    load_s  = 1'b0;
    shift_s = 1'b0;
    cap_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          state_d = LOAD;
          cnt_d   = '0;
          last_d  = in_last_i;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        shift_s = 1'b1;
        if (cnt_q == LD_LAST) begin
          state_d = MAC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      MAC: begin
        state_d = last_q ? FLUSH : IDLE;
        cnt_d   = '0;
      end
      FLUSH: begin
        if (cnt_q == LD_LAST) begin
          state_d = FMAC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      FMAC: begin
        state_d = READ;
        cnt_d   = '0;
      end
      READ: begin
        // The datapath registers its serial output, so bits arrive one cycle after each shift.
        cap_s = (cnt_q != '0);
        if (cnt_q == RD_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      shift_in_q  <= 1'b0;
      shift_out_q <= 1'b0;
      mac_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      in_ready_q  <= (state_d == IDLE);
      res_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      shift_in_q  <= (state_d == LOAD) || (state_d == FLUSH);
      shift_out_q <= (state_d == READ) && (cnt_d < AW_CNT);
      mac_q       <= (state_d == MAC) || (state_d == FMAC);
    end
  end

  percept_serdes #(.SIZE(SIZE)) u_serdes (
    .clk     (clk),
    .nRst    (nRst),
    .load_i  (load_s),
    .a_i     (in_a_i),
    .b_i     (in_b_i),
    .shift_i (shift_s),
    .cap_i   (cap_s),
    .sdo_i   (pc_data_out_i),
    .ser_o   (pc_data_in_o),
    .par_o   (result_o)
  );

  assign in_ready_o       = in_ready_q;
  assign res_valid_o      = res_valid_q;
  assign busy_o           = busy_q;
  assign pc_shift_in_o    = shift_in_q;
  assign pc_shift_out_o   = shift_out_q;
  assign pc_mul_and_acc_o = mac_q;

endmodule

// File: tb/tb_percept_ctrl.sv
// Self-checking bench for percept_ctrl with a behavioural bit-serial MAC datapath
// and a sum-of-products scoreboard.
import percept_pkg::*;

module tb_percept_ctrl;

  localparam int unsigned S  = 32;
  localparam int unsigned AW = 4 * S;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [S-1:0]  in_a = '0;
  logic [S-1:0]  in_b = '0;
  logic          in_last = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [AW-1:0] result;
  logic          busy;
  logic          pc_shift_in, pc_shift_out, pc_mul_and_acc, pc_data_in, pc_data_out;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  percept_ctrl #(.SIZE(S)) dut (
    .clk              (clk),
    .nRst             (nRst),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_a_i           (in_a),
    .in_b_i           (in_b),
    .in_last_i        (in_last),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .result_o         (result),
    .busy_o           (busy),
    .pc_shift_in_o    (pc_shift_in),
    .pc_shift_out_o   (pc_shift_out),
    .pc_mul_and_acc_o (pc_mul_and_acc),
    .pc_data_in_o     (pc_data_in),
    .pc_data_out_i    (pc_data_out)
  );

  // Datapath model: operand chain {data_2,data_1}, one-deep product register, accumulator.
  logic [2*S-1:0] m_chain;
  logic [2*S-1:0] m_prod;
  logic [AW-1:0]  m_acc;
  logic           m_dout;
  assign pc_data_out = m_dout;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_chain <= '0;
      m_prod  <= '0;
      m_acc   <= '0;
      m_dout  <= 1'b0;
    end else begin
      if (pc_shift_in) m_chain <= {m_chain[2*S-2:0], pc_data_in};
      if (pc_mul_and_acc) begin
        m_prod <= m_chain[2*S-1:S] * m_chain[S-1:0];
        m_acc  <= m_acc + AW'(m_prod);
      end
      if (pc_shift_out) begin
        m_dout <= m_acc[AW-1];
        m_acc  <= {m_acc[AW-2:0], 1'b0};
      end
    end
  end

  // Strobe exclusivity and idle-low serial data, checked every cycle.
  initial begin
    forever begin
      @(negedge clk);
      total++;
      if ($countones({pc_shift_in, pc_shift_out, pc_mul_and_acc}) > 1 || (!pc_shift_in && pc_data_in)) begin
        bad++;
        $display("FAIL strobe_rules: got si=%0b so=%0b mac=%0b din=%0b required at most one strobe, din=0 without shift_in",
                 pc_shift_in, pc_shift_out, pc_mul_and_acc, pc_data_in);
      end
    end
  end

  task automatic send_pair(input logic [S-1:0] a, input logic [S-1:0] b, input logic last,
                           input int gap, output int unsigned h);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    n = 0;
    while (!in_ready && n < 400) begin @(posedge clk); #1; n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL handshake_wait: in_ready=%0b required 1", in_ready);
    end
    h = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_last = 1'($urandom);
  endtask

  task automatic wait_result(input logic [AW-1:0] expv, input string name, output int unsigned t);
    int n;
    n = 0;
    while (!res_valid && n < 3000) begin @(posedge clk); #1; n++; end
    t = cyc;
    total++;
    if (res_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: res_valid=%0b required 1", name, res_valid);
    end
    total++;
    if (result !== expv) begin
      bad++;
      $display("FAIL %s_result: got %h required %h", name, result, expv);
    end
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_flags: in_ready=%0b busy=%0b required 0 1", name, in_ready, busy);
    end
  endtask

  task automatic consume(input int delay, input string name);
    repeat (delay) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_release: res_valid=%0b in_ready=%0b busy=%0b required 0 1 0",
               name, res_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || busy !== 1'b0 ||
        pc_shift_in !== 1'b0 || pc_shift_out !== 1'b0 || pc_mul_and_acc !== 1'b0 || pc_data_in !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rdy=%0b rv=%0b res=%h busy=%0b pc=%0b%0b%0b%0b required 1 0 0 0 0000",
               in_ready, res_valid, result, busy, pc_shift_in, pc_shift_out, pc_mul_and_acc, pc_data_in);
    end
    nRst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int unsigned h, t;
    send_pair(32'd3, 32'd5, 1'b1, 0, h);
    wait_result(AW'(15), "single", t);
    total++;
    if (t - h !== 32'd260) begin
      bad++;
      $display("FAIL single_latency: got %0d required 260", t - h);
    end
    consume(0, "single");
  endtask

  task automatic test_two_pairs();
    int unsigned h, h2, t;
    send_pair(32'd2, 32'd7, 1'b0, 0, h);
    in_valid = 1'b1;
    send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, h2);
    wait_result(AW'(64'hFFFF_FFFE_0000_000F), "two_pairs", t);
    total++;
    if (t - h !== 32'd326) begin
      bad++;
      $display("FAIL two_pairs_latency: got %0d required 326", t - h);
    end
    consume(2, "two_pairs");
  endtask

  task automatic test_back_to_back();
    int unsigned h, t;
    send_pair(32'd1, 32'd1, 1'b1, 0, h);
    wait_result(AW'(1), "b2b_first", t);
    consume(0, "b2b_first");
    send_pair(32'd4, 32'd4, 1'b1, 0, h);
    wait_result(AW'(16), "b2b_second", t);
    consume(0, "b2b_second");
  endtask

  task automatic test_hold();
    int unsigned h, t;
    send_pair(32'd5, 32'd6, 1'b1, 1, h);
    wait_result(AW'(30), "hold", t);
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'($urandom);
      in_a = $urandom; in_b = $urandom; in_last = 1'($urandom);
      @(posedge clk); #1;
      total++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || result !== AW'(30)) begin
        bad++;
        $display("FAIL hold_stable: rv=%0b rdy=%0b res=%h required 1 0 %h", res_valid, in_ready, result, AW'(30));
      end
    end
    in_valid = 1'b0;
    consume(0, "hold");
  endtask

  task automatic test_reset_mid();
    int unsigned h, t;
    send_pair(32'd9, 32'd9, 1'b1, 0, h);
    repeat (10) @(posedge clk);
    #1;
    nRst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || busy !== 1'b0 ||
        pc_shift_in !== 1'b0 || pc_shift_out !== 1'b0 || pc_mul_and_acc !== 1'b0 || pc_data_in !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: rdy=%0b rv=%0b res=%h busy=%0b pc=%0b%0b%0b%0b required 1 0 0 0 0000",
               in_ready, res_valid, result, busy, pc_shift_in, pc_shift_out, pc_mul_and_acc, pc_data_in);
    end
    repeat (2) @(posedge clk);
    #1;
    nRst = 1'b1;
    @(posedge clk); #1;
    send_pair(32'd2, 32'd3, 1'b1, 0, h);
    wait_result(AW'(6), "after_reset", t);
    consume(1, "after_reset");
  endtask

  task automatic test_random();
    int unsigned h, t;
    int          np;
    logic [S-1:0]  a, b;
    logic [AW-1:0] expv;
    for (int j = 0; j < 100; j++) begin
      np   = $urandom_range(1, 4);
      expv = '0;
      for (int k = 0; k < np; k++) begin
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 7) == 0) a = '1;
        if ($urandom_range(0, 7) == 0) b = '0;
        expv = expv + AW'(a) * AW'(b);
        send_pair(a, b, (k == np - 1), $urandom_range(0, 3), h);
      end
      wait_result(expv, "random", t);
      consume($urandom_range(0, 5), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pairs();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
